// File: rtl/systolic_mem_responder_pkg.sv
// Shared types and defaults for the systolic array memory responder.
//   resp_state_t  : sequencer states (IDLE, LAUNCH, RUN, DRAIN, DONE)
//   DEFAULT_*     : default geometry used by the responder and its RAM
package systolic_mem_responder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DEPTH  = 64;

    typedef enum logic [2:0] {
        R_IDLE,
        R_LAUNCH,
        R_RUN,
        R_DRAIN,
        R_DONE
    } resp_state_t;

endpackage

// File: rtl/systolic_dp_ram.sv
// Word-addressed data RAM: one write port and two registered read ports.
//   clk, rst          : clock, asynchronous active-low reset (read registers only)
//   i_we/i_waddr/i_wdata : single write port
//   i_a_en/i_a_addr -> o_a_data : read port A, 1-cycle latency, 0 when not enabled
//   i_b_en/i_b_addr -> o_b_data : read port B, 1-cycle latency, 0 when not enabled
module systolic_dp_ram
    import systolic_mem_responder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_a_en,
    input  logic [IDX_W-1:0] i_a_addr,
    output logic [WIDTH-1:0] o_a_data,
    input  logic             i_b_en,
    input  logic [IDX_W-1:0] i_b_addr,
    output logic [WIDTH-1:0] o_b_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;

    // NOTE: the storage array has no reset so it maps onto block RAM; its
    // contents survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking updates mean a read and write to the same word on one
    // edge return the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_data <= '0;
            r_b_data <= '0;
        end else begin
            r_a_data <= i_a_en ? r_mem[i_a_addr] : '0;
            r_b_data <= i_b_en ? r_mem[i_b_addr] : '0;
        end
    end

    assign o_a_data = r_a_data;
    assign o_b_data = r_b_data;

endmodule

// File: rtl/systolic_mem_responder.sv
// Memory-side responder for the systolic array's memory master port.
// Owns the data RAM, services host loads/readbacks while idle, and sequences
// one matrix operation per accepted host_start.
//   clk, rst                     : clock, asynchronous active-low reset
//   act_addr/mem_write/mem_data_write -> mem_read : array memory port
//   array_idle in, new_data out  : array handshake (launch pulse, idle status)
//   addr_A/addr_B/addr_C, n      : operand/result bases and array dimension
//   host_req/we/addr/wdata -> host_ack/host_rdata : host RAM access
//   host_start, cfg_addr_a/b/c   : operation launch and base addresses
//   busy, done, err_range, err_timeout, wr_count : status
module systolic_mem_responder
    import systolic_mem_responder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       act_addr,
    input  logic                    mem_write,
    input  logic signed [WIDTH-1:0] mem_data_write,
    output logic signed [WIDTH-1:0] mem_read,
    input  logic                    array_idle,
    output logic                    new_data,
    output logic [ADDR_W-1:0]       addr_A,
    output logic [ADDR_W-1:0]       addr_B,
    output logic [ADDR_W-1:0]       addr_C,
    output logic [3:0]              n,
    input  logic                    host_req,
    input  logic                    host_we,
    input  logic [ADDR_W-1:0]       host_addr,
    input  logic [WIDTH-1:0]        host_wdata,
    output logic                    host_ack,
    output logic [WIDTH-1:0]        host_rdata,
    input  logic                    host_start,
    input  logic [ADDR_W-1:0]       cfg_addr_a,
    input  logic [ADDR_W-1:0]       cfg_addr_b,
    input  logic [ADDR_W-1:0]       cfg_addr_c,
    output logic                    busy,
    output logic                    done,
    output logic                    err_range,
    output logic                    err_timeout,
    output logic [7:0]              wr_count
);

    localparam int                IDX_W      = $clog2(DEPTH);
    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

    resp_state_t       r_state;
    logic              r_new_data, r_busy, r_done, r_err_timeout;
    logic              r_host_ack, r_err_range;
    logic [7:0]        r_wr_count;
    logic [CNT_W-1:0]  r_cycle;
    logic [ADDR_W-1:0] r_addr_a, r_addr_b, r_addr_c;

    logic              w_act_in, w_host_in, w_run, w_start;
    logic              w_host_acc, w_arr_wr, w_host_wr, w_range_hit;
    logic [WIDTH-1:0]  w_wdata, w_a_data, w_b_data;
    logic [IDX_W-1:0]  w_waddr;

    assign w_act_in    = act_addr < ADDR_LIMIT;
    assign w_host_in   = host_addr < ADDR_LIMIT;
    assign w_run       = (r_state == R_RUN) || (r_state == R_DRAIN);
    assign w_start     = (r_state == R_IDLE) && host_start && array_idle && !host_req;
    // A request still high during its own ack cycle is not taken twice.
    assign w_host_acc  = (r_state == R_IDLE) && host_req && !r_host_ack;
    assign w_arr_wr    = w_run && mem_write && w_act_in;
    assign w_host_wr   = w_host_acc && host_we && w_host_in;
    // The array port reads every cycle, so an out-of-range act_addr always counts.
    assign w_range_hit = !w_act_in || (w_host_acc && !w_host_in);

    // Host and array writes never coincide: the host is only served in IDLE.
    assign w_waddr = w_arr_wr ? act_addr[IDX_W-1:0] : host_addr[IDX_W-1:0];
    assign w_wdata = w_arr_wr ? $unsigned(mem_data_write) : host_wdata;

    systolic_dp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_arr_wr || w_host_wr),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_a_en   (w_act_in),
        .i_a_addr (act_addr[IDX_W-1:0]),
        .o_a_data (w_a_data),
        .i_b_en   (w_host_acc && !host_we && w_host_in),
        .i_b_addr (host_addr[IDX_W-1:0]),
        .o_b_data (w_b_data)
    );

    // Sequencer. r_cycle counts cycles since LAUNCH, so an operation that
    // times out holds busy for exactly TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= R_IDLE;
            r_new_data    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cycle       <= '0;
            r_addr_a      <= '0;
            r_addr_b      <= '0;
            r_addr_c      <= '0;
        end else begin
            // NOTE: pulse outputs fall by default; only the transition that
            // needs one raises it for a single cycle.
            r_new_data <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (w_start) begin
                        r_state       <= R_LAUNCH;
                        r_new_data    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_err_timeout <= 1'b0;
                        r_cycle       <= '0;
                        r_addr_a      <= cfg_addr_a;
                        r_addr_b      <= cfg_addr_b;
                        r_addr_c      <= cfg_addr_c;
                    end
                end
                R_LAUNCH: begin
                    r_state <= R_RUN;
                    r_cycle <= r_cycle + CNT_W'(1);
                end
                R_RUN, R_DRAIN: begin
                    if (r_cycle == CNT_LAST) begin
                        r_state       <= R_IDLE;
                        r_busy        <= 1'b0;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_cycle <= r_cycle + CNT_W'(1);
                        if (r_state == R_RUN && !array_idle) begin
                            r_state <= R_DRAIN;
                        end else if (r_state == R_DRAIN && array_idle) begin
                            r_state <= R_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                R_DONE:  r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Host acknowledge, write counter and range error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_host_ack  <= 1'b0;
            r_wr_count  <= '0;
            r_err_range <= 1'b0;
        end else begin
            r_host_ack <= w_host_acc;
            if (w_start) begin
                r_wr_count <= '0;
            end else if (w_arr_wr && r_wr_count != 8'hFF) begin
                r_wr_count <= r_wr_count + 8'd1;
            end
            // A range hit on the start edge itself is kept.
            if (w_range_hit) begin
                r_err_range <= 1'b1;
            end else if (w_start) begin
                r_err_range <= 1'b0;
            end
        end
    end

    assign mem_read    = $signed(w_a_data);
    assign host_rdata  = w_b_data;
    assign new_data    = r_new_data;
    assign addr_A      = r_addr_a;
    assign addr_B      = r_addr_b;
    assign addr_C      = r_addr_c;
    assign n           = 4'(N);
    assign host_ack    = r_host_ack;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_range   = r_err_range;
    assign err_timeout = r_err_timeout;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_systolic_mem_responder.sv
// Self-checking bench for systolic_mem_responder. The main instance runs host
// loads, a full N=4 operation with an emulated array, contention and a
// mid-operation reset; a second instance with TIMEOUT=16 covers the timeout.
module tb_systolic_mem_responder;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } host_vec_t;

    logic clk, rst;
    logic [11:0] act_addr;
    logic        mem_write;
    logic signed [15:0] mem_data_write, mem_read;
    logic        array_idle, new_data;
    logic [11:0] addr_A, addr_B, addr_C;
    logic [3:0]  n_out;
    logic        host_req, host_we, host_ack;
    logic [11:0] host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        host_start;
    logic [11:0] cfg_addr_a, cfg_addr_b, cfg_addr_c;
    logic        busy, done, err_range, err_timeout;
    logic [7:0]  wr_count;

    logic        t_start;
    logic signed [15:0] t_mem_read;
    logic        t_new_data, t_host_ack, t_busy, t_done, t_err_range, t_err_timeout;
    logic [11:0] t_addr_a, t_addr_b, t_addr_c;
    logic [3:0]  t_n;
    logic [15:0] t_host_rdata;
    logic [7:0]  t_wr_count;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int nd_cnt = 0, done_cnt = 0, done_cyc = 0, ack_cyc = 0, ack_busy = 0;
    int t_nd_cnt = 0, t_done_cnt = 0;

    logic [15:0] mdl [64];
    logic [15:0] q_host[$];
    logic [15:0] q_arr[$];
    host_vec_t   load_vecs[$];
    host_vec_t   post_vecs[$];

    systolic_mem_responder #(.WIDTH(16), .ADDR_W(12), .DEPTH(64), .N(4), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .act_addr(act_addr), .mem_write(mem_write),
        .mem_data_write(mem_data_write), .mem_read(mem_read), .array_idle(array_idle),
        .new_data(new_data), .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .n(n_out),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_start(host_start),
        .cfg_addr_a(cfg_addr_a), .cfg_addr_b(cfg_addr_b), .cfg_addr_c(cfg_addr_c),
        .busy(busy), .done(done), .err_range(err_range), .err_timeout(err_timeout),
        .wr_count(wr_count)
    );

    systolic_mem_responder #(.WIDTH(16), .ADDR_W(12), .DEPTH(64), .N(4), .TIMEOUT(16)) u_to (
        .clk(clk), .rst(rst), .act_addr(12'd0), .mem_write(1'b0),
        .mem_data_write(16'sd0), .mem_read(t_mem_read), .array_idle(1'b1),
        .new_data(t_new_data), .addr_A(t_addr_a), .addr_B(t_addr_b), .addr_C(t_addr_c), .n(t_n),
        .host_req(1'b0), .host_we(1'b0), .host_addr(12'd0), .host_wdata(16'd0),
        .host_ack(t_host_ack), .host_rdata(t_host_rdata), .host_start(t_start),
        .cfg_addr_a(12'h111), .cfg_addr_b(12'h122), .cfg_addr_c(12'h123),
        .busy(t_busy), .done(t_done), .err_range(t_err_range), .err_timeout(t_err_timeout),
        .wr_count(t_wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (new_data) nd_cnt <= nd_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (host_ack) begin
            ack_cyc <= cyc;
            if (busy) ack_busy <= ack_busy + 1;
        end
        if (t_new_data) t_nd_cnt <= t_nd_cnt + 1;
        if (t_done) t_done_cnt <= t_done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected element of C = A x B, A at word 0 and B at word 16, row-major.
    function automatic logic [15:0] c_val(input int r, input int c);
        logic [15:0] s;
        s = 16'd0;
        for (int k = 0; k < 4; k++) s = s + mdl[4*r+k] * mdl[16+4*k+c];
        return s;
    endfunction

    // One host access: reads push their expected data on the scoreboard and
    // pop it when the ack arrives. exp_lat of 0 skips the latency check.
    task automatic host_access(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                               input logic [15:0] exp, input int exp_lat, input string name);
        int          lat;
        logic [15:0] want;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        if (!we) q_host.push_back(exp);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!host_ack && lat < 200);
        check({name, " ack"}, host_ack, 1);
        if (exp_lat > 0) check({name, " latency"}, lat, exp_lat);
        if (!we && q_host.size() > 0) begin
            want = q_host.pop_front();
            if (host_ack) check({name, " data"}, host_rdata, want);
        end
        if (we && addr < 12'd64) mdl[addr[5:0]] = wdata;
        host_req = 1'b0;
        host_we  = 1'b0;
        step();
    endtask

    initial begin
        int busy_drop;
        int cycles;

        // Stimulus tables.
        for (int i = 0; i < 16; i++) load_vecs.push_back('{1'b1, 12'(i), 16'(i + 1), 16'd0});
        for (int i = 0; i < 16; i++) load_vecs.push_back('{1'b1, 12'(16 + i), 16'(2 * (i + 1)), 16'd0});
        load_vecs.push_back('{1'b0, 12'd5,  16'd0, 16'd6});
        load_vecs.push_back('{1'b0, 12'd20, 16'd0, 16'd10});
        post_vecs.push_back('{1'b0, 12'd32, 16'd0, 16'd180});
        post_vecs.push_back('{1'b0, 12'd36, 16'd0, 16'd404});
        post_vecs.push_back('{1'b0, 12'd47, 16'd0, 16'd1200});
        post_vecs.push_back('{1'b0, 12'd70, 16'd0, 16'd0});
        post_vecs.push_back('{1'b1, 12'd70, 16'hBEEF, 16'd0});
        post_vecs.push_back('{1'b0, 12'd6,  16'd0, 16'd7});
        post_vecs.push_back('{1'b0, 12'd0,  16'd0, 16'd1});

        rst = 1'b1; act_addr = '0; mem_write = 1'b0; mem_data_write = '0;
        array_idle = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        host_wdata = '0; host_start = 1'b0; t_start = 1'b0;
        cfg_addr_a = '0; cfg_addr_b = '0; cfg_addr_c = '0;
        for (int i = 0; i < 64; i++) mdl[i] = 16'd0;

        // Asynchronous reset asserted mid-cycle.
        step();
        step();
        #3 rst = 1'b0;
        #1;
        check("reset mem_read", $unsigned(mem_read), 0);
        check("reset new_data/busy/done", {new_data, busy, done}, 0);
        check("reset addr_A/B/C", {addr_A, addr_B, addr_C}, 0);
        check("reset host_ack/rdata", {host_ack, host_rdata}, 0);
        check("reset errors/wr_count", {err_range, err_timeout, wr_count}, 0);
        check("reset n", n_out, 4);
        step();
        rst = 1'b1;
        step();

        // Host load and readback.
        for (int i = 0; i < load_vecs.size(); i++)
            host_access(load_vecs[i].we, load_vecs[i].addr, load_vecs[i].wdata, load_vecs[i].exp, 1,
                        $sformatf("host %s @%0d", load_vecs[i].we ? "wr" : "rd", load_vecs[i].addr));

        // Array write in IDLE is dropped silently.
        mem_write = 1'b1; act_addr = 12'd0; mem_data_write = 16'sd999;
        step();
        mem_write = 1'b0;
        check("idle array write: wr_count", wr_count, 0);
        check("idle array write: err_range", err_range, 0);

        // Full operation.
        cfg_addr_a = 12'd0; cfg_addr_b = 12'd16; cfg_addr_c = 12'd32;
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        check("op1 launch new_data", new_data, 1);
        check("op1 launch busy", busy, 1);
        check("op1 latched bases", {addr_A, addr_B, addr_C}, {12'd0, 12'd16, 12'd32});
        step();
        check("op1 new_data one cycle", new_data, 0);
        act_addr = 12'd3;
        q_arr.push_back(mdl[3]);
        step();
        check("array read addr 3", $unsigned(mem_read), q_arr.pop_front());
        act_addr = 12'd17;
        q_arr.push_back(mdl[17]);
        step();
        check("array read addr 17", $unsigned(mem_read), q_arr.pop_front());
        array_idle = 1'b0;
        busy_drop = 0;
        for (int i = 0; i < 16; i++) begin
            act_addr = 12'(32 + i);
            mem_data_write = c_val(i / 4, i % 4);
            mem_write = 1'b1;
            step();
            if (!busy) busy_drop++;
        end
        for (int i = 0; i < 16; i++) mdl[32+i] = c_val(i / 4, i % 4);
        act_addr = 12'd100;
        mem_data_write = 16'sh5555;
        step();
        check("out-of-range array read", $unsigned(mem_read), 0);
        mem_write = 1'b0;
        act_addr = 12'd0;
        array_idle = 1'b1;
        for (int k = 0; k < 20 && !done; k++) step();
        check("op1 done pulse", done, 1);
        check("op1 busy through run", busy_drop, 0);
        check("op1 busy low at done", busy, 0);
        check("op1 wr_count", wr_count, 16);
        check("op1 err_range sticky", err_range, 1);
        check("op1 err_timeout", err_timeout, 0);
        step();
        check("op1 done one cycle", done, 0);
        check("op1 new_data pulses", nd_cnt, 1);
        check("op1 done pulses", done_cnt, 1);

        for (int i = 0; i < post_vecs.size(); i++)
            host_access(post_vecs[i].we, post_vecs[i].addr, post_vecs[i].wdata, post_vecs[i].exp, 1,
                        $sformatf("post %s @%0d", post_vecs[i].we ? "wr" : "rd", post_vecs[i].addr));
        check("err_range held until start", err_range, 1);

        // Contention: host request while busy, plus an ignored second start.
        cfg_addr_c = 12'd48;
        host_start = 1'b1;
        step();
        check("op2 wr_count cleared", wr_count, 0);
        check("op2 err_range cleared", err_range, 0);
        check("op2 addr_C", addr_C, 48);
        fork
            begin
                step();
                host_access(1'b0, 12'd5, 16'd0, mdl[5], 0, "contention read");
            end
            begin
                step();
                array_idle = 1'b0;
                step();
                step();
                step();
                host_start = 1'b0;
                array_idle = 1'b1;
                for (int k = 0; k < 30 && !done; k++) step();
                check("op2 done pulse", done, 1);
            end
        join
        check("contention ack cycle after done", ack_cyc - done_cyc, 2);
        check("no ack while busy", ack_busy, 0);
        check("start during busy ignored", nd_cnt, 2);
        check("op2 done pulses", done_cnt, 2);

        // Reset mid-operation keeps RAM.
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        array_idle = 1'b0;
        step();
        step();
        #3 rst = 1'b0;
        #1;
        check("mid-op reset busy", busy, 0);
        check("mid-op reset mem_read", $unsigned(mem_read), 0);
        step();
        rst = 1'b1;
        array_idle = 1'b1;
        step();
        host_access(1'b0, 12'd32, 16'd0, 16'd180, 1, "RAM kept over reset");

        // Timeout on the TIMEOUT=16 instance.
        t_start = 1'b1;
        step();
        t_start = 1'b0;
        check("timeout launch busy", t_busy, 1);
        check("timeout latched addr_C", t_addr_c, 12'h123);
        cycles = 0;
        while (t_busy && cycles < 40) begin
            cycles++;
            step();
        end
        check("timeout busy cycles", cycles, 16);
        check("timeout err_timeout", t_err_timeout, 1);
        check("timeout no done", t_done_cnt, 0);
        check("timeout new_data pulses", t_nd_cnt, 1);
        t_start = 1'b1;
        step();
        t_start = 1'b0;
        check("err_timeout cleared on start", t_err_timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
